shared_pipe_arbiter: RTL and testbench

SHARED_PIPE_ARBITER -- requirements
Module: shared_pipe_arbiter

---
 rtl/shared_pipe_arbiter.sv | 118 +++++++++++
 tb/tb_shared_pipe_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_pipe_arbiter.sv
// Round-robin arbiter feeding a fixed-latency, bubble-shifting shared pipeline.
// Defining SHARED_PIPE_FLUSH_EN adds a flush input that drops every in-flight transfer.
module shared_pipe_arbiter #(
  parameter int width = 8,
  parameter int depth = 8,
  parameter int n_req = 4
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef SHARED_PIPE_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic [n_req-1:0]           req,
  input  logic [n_req*width-1:0]     req_data,
  output logic [n_req-1:0]           gnt,
  output logic [n_req-1:0]           out_vld,
  output logic [width-1:0]           out_data,
  output logic [$clog2(depth+1)-1:0] in_flight,
  output logic                       busy
);

  localparam int id_w  = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int cnt_w = $clog2(depth + 1);

  function automatic logic [id_w-1:0] rr_next(input logic [id_w-1:0] idx, input int step);
    return id_w'((int'(idx) + step) % n_req);
  endfunction

  function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] c);
    return (int'(c) >= depth) ? c : c + cnt_w'(1);
  endfunction

  function automatic logic [cnt_w-1:0] sat_dec(input logic [cnt_w-1:0] c);
    return (c == '0) ? c : c - cnt_w'(1);
  endfunction

  logic [id_w-1:0]  rr_ptr;
  logic [id_w-1:0]  cand;
  logic [id_w-1:0]  gnt_idx;
  logic             gnt_any;
  logic             kill;
  logic             exit_vld;

  logic             vld_p  [depth];
  logic [id_w-1:0]  tag_p  [depth];
  logic [width-1:0] data_p [depth];

`ifdef SHARED_PIPE_FLUSH_EN
  assign kill = rst | flush;
`else
  assign kill = rst;
`endif

  // Arbitration: first requester at or after rr_ptr, wrapping at n_req
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < n_req; i++) begin
      cand = rr_next(rr_ptr, i);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (kill) gnt_any = 1'b0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign exit_vld = vld_p[depth-1];

  // Stage 0 load, stage shift and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      in_flight <= '0;
      for (int s = 0; s < depth; s++) begin
        vld_p[s]  <= 1'b0;
        tag_p[s]  <= '0;
        data_p[s] <= '0;
      end
    end else begin
      if (gnt_any) rr_ptr <= rr_next(gnt_idx, 1);
      vld_p[0]  <= gnt_any;
      tag_p[0]  <= gnt_idx;
      data_p[0] <= req_data[int'(gnt_idx)*width +: width];
      for (int s = 1; s < depth; s++) begin
        vld_p[s]  <= vld_p[s-1];
        tag_p[s]  <= tag_p[s-1];
        data_p[s] <= data_p[s-1];
      end
      case ({gnt_any, exit_vld})
        2'b10:   in_flight <= sat_inc(in_flight);
        2'b01:   in_flight <= sat_dec(in_flight);
        default: in_flight <= in_flight;
      endcase
`ifdef SHARED_PIPE_FLUSH_EN
      if (flush) begin
        for (int s = 0; s < depth; s++) vld_p[s] <= 1'b0;
        in_flight <= '0;
      end
`endif
    end
  end

  // Last stage decode
  always_comb begin
    out_vld = '0;
    for (int i = 0; i < n_req; i++) begin
      if (exit_vld && (tag_p[depth-1] == id_w'(i))) out_vld[i] = 1'b1;
    end
  end

  assign out_data = data_p[depth-1];
  assign busy     = (in_flight != '0);

endmodule

// File: tb/tb_shared_pipe_arbiter.sv
// Randomised and directed bench for shared_pipe_arbiter against a grant-history model.
module tb_shared_pipe_arbiter;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int N  = 4;
  localparam int CW = $clog2(D + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fl_in = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*W-1:0]    req_data = '0;
  logic [N-1:0]      gnt;
  logic [N-1:0]      out_vld;
  logic [W-1:0]      out_data;
  logic [CW-1:0]     in_flight;
  logic              busy;

  shared_pipe_arbiter #(.width(W), .depth(D), .n_req(N)) dut (
    .clk(clk),
    .rst(rst),
`ifdef SHARED_PIPE_FLUSH_EN
    .flush(fl_in),
`endif
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .out_vld(out_vld),
    .out_data(out_data),
    .in_flight(in_flight),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: a history of every cycle's grant; outputs and occupancy are read off it.
  int         cyc = 0;
  int         rr_m = 0;
  int         valid_from = 0;
  logic       g_vld  [2048];
  int         g_tag  [2048];
  logic [W-1:0] g_data [2048];
  int         gnt_k;
  logic [N-1:0] exp_gnt;
  logic [N-1:0] exp_out_vld;
  logic [W-1:0] exp_out_data;
  logic       exp_has_out;
  int         exp_inflight;

  function automatic void model_expect();
    int p;
    int lo;
    gnt_k = -1;
    if (!(rst || fl_in)) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (rr_m + i) % N;
        if (gnt_k < 0 && req[c]) gnt_k = c;
      end
    end
    exp_gnt = '0;
    if (gnt_k >= 0) exp_gnt[gnt_k] = 1'b1;
    p = cyc - D;
    exp_out_vld = '0;
    exp_out_data = '0;
    exp_has_out = 1'b0;
    if (p >= 0 && p >= valid_from && g_vld[p]) begin
      exp_has_out = 1'b1;
      exp_out_vld[g_tag[p]] = 1'b1;
      exp_out_data = g_data[p];
    end
    lo = (valid_from > cyc - D) ? valid_from : cyc - D;
    exp_inflight = 0;
    for (int g = lo; g < cyc; g++) begin
      if (g >= 0 && g_vld[g]) exp_inflight++;
    end
  endfunction

  function automatic void model_commit();
    g_vld[cyc]  = (gnt_k >= 0);
    g_tag[cyc]  = (gnt_k >= 0) ? gnt_k : 0;
    g_data[cyc] = (gnt_k >= 0) ? req_data[gnt_k*W +: W] : '0;
    if (gnt_k >= 0) rr_m = (gnt_k + 1) % N;
    if (rst) begin
      rr_m = 0;
      valid_from = cyc + 1;
    end else if (fl_in) begin
      valid_from = cyc + 1;
    end
    cyc++;
  endfunction

  task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d, input logic f);
    @(negedge clk);
    rst = r;
    req = rq;
    req_data = d;
    fl_in = f;
    #1;
    model_expect();
  endtask

  task automatic apply_reset();
    drive(1'b1, '0, '0, 1'b0);
    model_commit();
    drive(1'b1, '0, '0, 1'b0);
    model_commit();
  endtask

  task automatic test_reset();
    drive(1'b1, 4'b1111, 32'h1234_5678, 1'b0);
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    model_commit();
    drive(1'b1, 4'b1111, 32'h1234_5678, 1'b0);
    model_commit();
    drive(1'b0, 4'b0000, 32'h0, 1'b0);
    checks++;
    if (out_vld !== '0 || out_data !== '0) begin
      failures++; $display("FAIL reset_out got=%b/%h exp=0000/00", out_vld, out_data);
    end
    checks++;
    if (in_flight !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_count got=%0d/%b exp=0/0", in_flight, busy);
    end
    model_commit();
  endtask

  task automatic test_single();
    apply_reset();
    drive(1'b0, 4'b0001, 32'h0000_00A5, 1'b0);
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    model_commit();
    for (int k = 1; k <= 9; k++) begin
      drive(1'b0, 4'b0000, 32'h0, 1'b0);
      checks++;
      if (in_flight !== CW'((k <= 8) ? 1 : 0)) begin
        failures++; $display("FAIL single_inflight cyc=%0d got=%0d exp=%0d", k, in_flight, (k <= 8) ? 1 : 0);
      end
      checks++;
      if (out_vld !== ((k == 8) ? 4'b0001 : 4'b0000)) begin
        failures++; $display("FAIL single_out_vld cyc=%0d got=%b", k, out_vld);
      end
      if (k == 8) begin
        checks++;
        if (out_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", out_data); end
      end
      model_commit();
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, (k < 8) ? 4'b1111 : 4'b0000, $urandom(), 1'b0);
      checks++;
      if (gnt !== ((k < 8) ? 4'(1 << (k % 4)) : 4'b0000)) begin
        failures++; $display("FAIL rr_gnt cyc=%0d got=%b", k, gnt);
      end
      if (k >= 8) begin
        checks++;
        if (out_vld !== 4'(1 << ((k - 8) % 4)) || out_data !== exp_out_data) begin
          failures++; $display("FAIL rr_out cyc=%0d got=%b/%h exp=%b/%h", k, out_vld, out_data,
                               4'(1 << ((k - 8) % 4)), exp_out_data);
        end
      end
      model_commit();
    end
  endtask

  task automatic test_skip_wrap();
    apply_reset();
    drive(1'b0, 4'b0100, $urandom(), 1'b0);
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL skip_setup got=%b exp=0100", gnt); end
    model_commit();
    drive(1'b0, 4'b0101, $urandom(), 1'b0);
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL skip_wrap got=%b exp=0001", gnt); end
    model_commit();
    drive(1'b0, 4'b0101, $urandom(), 1'b0);
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL skip_next got=%b exp=0100", gnt); end
    model_commit();
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 24; k++) begin
      drive(1'b0, 4'b1111, $urandom(), 1'b0);
      checks++;
      if (in_flight !== CW'((k < D) ? k : D) || busy !== (k > 0)) begin
        failures++; $display("FAIL sat_count cyc=%0d got=%0d/%b exp=%0d", k, in_flight, busy, (k < D) ? k : D);
      end
      if (k >= D) begin
        checks++;
        if (out_vld !== exp_out_vld || out_vld == '0 || out_data !== exp_out_data) begin
          failures++; $display("FAIL sat_out cyc=%0d got=%b/%h exp=%b/%h", k, out_vld, out_data, exp_out_vld, exp_out_data);
        end
      end
      model_commit();
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int k = 0; k < 13; k++) begin
      drive(k == 4, (k < 3) ? 4'b1111 : 4'b0000, $urandom(), 1'b0);
      checks++;
      if (in_flight !== CW'(exp_inflight)) begin
        failures++; $display("FAIL midrst_inflight cyc=%0d got=%0d exp=%0d", k, in_flight, exp_inflight);
      end
      if (k >= 5) begin
        checks++;
        if (out_vld !== 4'b0000 || in_flight !== '0) begin
          failures++; $display("FAIL midrst_out cyc=%0d got=%b/%0d exp=0000/0", k, out_vld, in_flight);
        end
      end
      model_commit();
    end
  endtask

`ifdef SHARED_PIPE_FLUSH_EN
  task automatic test_flush();
    int gcyc;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'b1111, $urandom(), 1'b0);
      model_commit();
    end
    drive(1'b0, 4'b0010, $urandom(), 1'b1);
    checks++;
    if (gnt !== 4'b0000 || in_flight !== CW'(5)) begin
      failures++; $display("FAIL flush_gnt got=%b/%0d exp=0000/5", gnt, in_flight);
    end
    model_commit();
    drive(1'b0, 4'b0011, 32'h0000_5A00, 1'b0);
    checks++;
    if (in_flight !== '0 || gnt !== 4'b0010) begin
      failures++; $display("FAIL flush_after got=%0d/%b exp=0/0010", in_flight, gnt);
    end
    model_commit();
    gcyc = 0;
    for (int k = 1; k <= D + 2; k++) begin
      drive(1'b0, 4'b0000, $urandom(), 1'b0);
      checks++;
      if (out_vld !== ((k == D) ? 4'b0010 : 4'b0000)) begin
        failures++; $display("FAIL flush_out cyc=%0d got=%b", k, out_vld);
      end
      if (k == D) begin
        gcyc++;
        checks++;
        if (out_data !== 8'h5A) begin failures++; $display("FAIL flush_data got=%h exp=5a", out_data); end
      end
      model_commit();
    end
  endtask
`endif

  task automatic test_random();
    logic f;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      f = 1'b0;
`ifdef SHARED_PIPE_FLUSH_EN
      f = ($urandom_range(0, 29) == 0);
`endif
      drive($urandom_range(0, 39) == 0, N'($urandom_range(0, (1 << N) - 1)), $urandom(), f);
      checks++;
      if (gnt !== exp_gnt) begin
        failures++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt);
      end
      checks++;
      if (out_vld !== exp_out_vld || (exp_has_out && out_data !== exp_out_data)) begin
        failures++; $display("FAIL rand_out cyc=%0d got=%b/%h exp=%b/%h", cyc, out_vld, out_data, exp_out_vld, exp_out_data);
      end
      checks++;
      if (in_flight !== CW'(exp_inflight) || busy !== (exp_inflight != 0)) begin
        failures++; $display("FAIL rand_inflight cyc=%0d got=%0d/%b exp=%0d", cyc, in_flight, busy, exp_inflight);
      end
      model_commit();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip_wrap();
    test_saturation();
    test_mid_reset();
`ifdef SHARED_PIPE_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
